stream_range_tracker: RTL and testbench

STREAM_RANGE_TRACKER -- requirements
Module: stream_range_tracker

---
 rtl/range_pkg.sv | 19 +
 rtl/stream_range_tracker_if.sv | 27 ++
 rtl/range_compare.sv | 17 +
 rtl/stream_range_tracker.sv | 115 +++++++++++
 tb/tb_stream_range_tracker.sv | 165 ++++++++++++++++
 5 files changed

// File: rtl/range_pkg.sv
// Shared types and the sign-aware compare helper for the stream range tracker.
package range_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        ERROR = 2'd2,
        DONE  = 2'd3
    } state_t;

    // With differing sign bits in signed mode, the operand with the clear sign bit is larger.
    function automatic logic cmp_gt(input logic signed_mode,
                                    input logic a_msb,
                                    input logic b_msb,
                                    input logic mag_gt);
        return (signed_mode && (a_msb != b_msb)) ? b_msb : mag_gt;
    endfunction

endpackage

// File: rtl/stream_range_tracker_if.sv
// Sample stream and result bus between a sample source and the range tracker.
interface stream_range_tracker_if #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned CNT_WIDTH = 8
);
    logic [WIDTH-1:0]     data_in;
    logic                 data_valid;
    logic                 go;
    logic                 finish;
    logic [WIDTH-1:0]     range;
    logic [WIDTH-1:0]     max_out;
    logic [WIDTH-1:0]     min_out;
    logic [CNT_WIDTH-1:0] count;
    logic                 count_sat;
    logic                 done;
    logic                 error;

    modport master (
        output data_in, data_valid, go, finish,
        input  range, max_out, min_out, count, count_sat, done, error
    );

    modport slave (
        input  data_in, data_valid, go, finish,
        output range, max_out, min_out, count, count_sat, done, error
    );
endinterface

// File: rtl/range_compare.sv
// Combinational magnitude compare, signed or unsigned depending on SIGNED_MODE.
module range_compare
    import range_pkg::*;
#(
    parameter int unsigned WIDTH       = 8,
    parameter bit          SIGNED_MODE = 1'b0
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             a_gt_b,
    output logic             a_lt_b
);

    assign a_gt_b = cmp_gt(SIGNED_MODE, a[WIDTH-1], b[WIDTH-1], a > b);
    assign a_lt_b = cmp_gt(SIGNED_MODE, b[WIDTH-1], a[WIDTH-1], b > a);

endmodule

// File: rtl/stream_range_tracker.sv
// Tracks max, min and sample count over a go..finish sequence and publishes range on completion.
module stream_range_tracker
    import range_pkg::*;
#(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned CNT_WIDTH   = 8,
    parameter int unsigned SIGNED_MODE = 0
) (
    input  logic                  clock,
    input  logic                  reset_n,
    stream_range_tracker_if.slave bus
);

    localparam logic [CNT_WIDTH-1:0] CNT_FULL = '1;

    state_t state, state_n;

    logic [WIDTH-1:0]     run_max, run_min, fin_max, fin_min;
    logic [CNT_WIDTH-1:0] run_cnt, fin_cnt;
    logic                 run_sat, fin_sat;
    logic                 max_gt, min_lt;
    logic                 max_lt_unused, min_gt_unused;
    logic                 start_c, accum_c, close_c;

    range_compare #(.WIDTH(WIDTH), .SIGNED_MODE(SIGNED_MODE != 0)) u_cmp_max (
        .a      (bus.data_in),
        .b      (run_max),
        .a_gt_b (max_gt),
        .a_lt_b (max_lt_unused)
    );

    range_compare #(.WIDTH(WIDTH), .SIGNED_MODE(SIGNED_MODE != 0)) u_cmp_min (
        .a      (bus.data_in),
        .b      (run_min),
        .a_gt_b (min_gt_unused),
        .a_lt_b (min_lt)
    );

    // State register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_n;
    end

    // Next-state logic
    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:  if (bus.finish)                  state_n = ERROR;
                   else if (bus.go)                 state_n = RUN;
            RUN:   if (bus.go)                      state_n = ERROR;
                   else if (bus.finish)             state_n = DONE;
            ERROR: if (bus.go && !bus.finish)       state_n = RUN;
            DONE:                                   state_n = IDLE;
            default:                                state_n = IDLE;
        endcase
    end

    assign start_c = (state != RUN) && (state_n == RUN);
    assign accum_c = (state == RUN) && !bus.go;
    assign close_c = accum_c && bus.finish;

    // Running values including this cycle's sample, when valid
    always_comb begin
        fin_max = run_max;
        fin_min = run_min;
        fin_cnt = run_cnt;
        fin_sat = run_sat;
        if (bus.data_valid) begin
            if (max_gt) fin_max = bus.data_in;
            if (min_lt) fin_min = bus.data_in;
            if (run_cnt == CNT_FULL) fin_sat = 1'b1;
            else                     fin_cnt = run_cnt + CNT_WIDTH'(1);
        end
    end

    // Running registers and published results
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            run_max       <= '0;
            run_min       <= '0;
            run_cnt       <= '0;
            run_sat       <= 1'b0;
            bus.range     <= '0;
            bus.max_out   <= '0;
            bus.min_out   <= '0;
            bus.count     <= '0;
            bus.count_sat <= 1'b0;
            bus.done      <= 1'b0;
            bus.error     <= 1'b0;
        end else begin
            if (start_c) begin
                run_max <= bus.data_in;
                run_min <= bus.data_in;
                run_cnt <= CNT_WIDTH'(1);
                run_sat <= 1'b0;
            end else if (accum_c) begin
                run_max <= fin_max;
                run_min <= fin_min;
                run_cnt <= fin_cnt;
                run_sat <= fin_sat;
            end
            if (close_c) begin
                bus.range     <= WIDTH'(fin_max - fin_min);
                bus.max_out   <= fin_max;
                bus.min_out   <= fin_min;
                bus.count     <= fin_cnt;
                bus.count_sat <= fin_sat;
            end
            bus.done  <= (state_n == DONE);
            bus.error <= (state_n == ERROR);
        end
    end

endmodule

// File: tb/tb_stream_range_tracker.sv
// Directed bench: unsigned, signed and narrow-counter trackers driven from one initial block.
module tb_stream_range_tracker;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    always #5 clock = ~clock;

    stream_range_tracker_if #(.WIDTH(8), .CNT_WIDTH(8)) bu ();
    stream_range_tracker_if #(.WIDTH(8), .CNT_WIDTH(8)) bs ();
    stream_range_tracker_if #(.WIDTH(8), .CNT_WIDTH(2)) bc ();

    stream_range_tracker #(.WIDTH(8), .CNT_WIDTH(8), .SIGNED_MODE(0)) dut_u (
        .clock(clock), .reset_n(reset_n), .bus(bu));
    stream_range_tracker #(.WIDTH(8), .CNT_WIDTH(8), .SIGNED_MODE(1)) dut_s (
        .clock(clock), .reset_n(reset_n), .bus(bs));
    stream_range_tracker #(.WIDTH(8), .CNT_WIDTH(2), .SIGNED_MODE(0)) dut_c (
        .clock(clock), .reset_n(reset_n), .bus(bc));

    task automatic cyc_u(input logic g, input logic f, input logic v, input logic [7:0] d);
        bu.go = g; bu.finish = f; bu.data_valid = v; bu.data_in = d;
        @(posedge clock); #1;
        bu.go = 1'b0; bu.finish = 1'b0; bu.data_valid = 1'b0; bu.data_in = '0;
    endtask

    task automatic cyc_s(input logic g, input logic f, input logic v, input logic [7:0] d);
        bs.go = g; bs.finish = f; bs.data_valid = v; bs.data_in = d;
        @(posedge clock); #1;
        bs.go = 1'b0; bs.finish = 1'b0; bs.data_valid = 1'b0; bs.data_in = '0;
    endtask

    task automatic cyc_c(input logic g, input logic f, input logic v, input logic [7:0] d);
        bc.go = g; bc.finish = f; bc.data_valid = v; bc.data_in = d;
        @(posedge clock); #1;
        bc.go = 1'b0; bc.finish = 1'b0; bc.data_valid = 1'b0; bc.data_in = '0;
    endtask

    task automatic test_reset();
        #1;
        checks++; if (bu.range !== 8'd0)   begin failures++; $display("FAIL reset_range got=%0d exp=0", bu.range); end
        checks++; if (bu.max_out !== 8'd0) begin failures++; $display("FAIL reset_max got=%0d exp=0", bu.max_out); end
        checks++; if (bu.min_out !== 8'd0) begin failures++; $display("FAIL reset_min got=%0d exp=0", bu.min_out); end
        checks++; if (bu.count !== 8'd0)   begin failures++; $display("FAIL reset_count got=%0d exp=0", bu.count); end
        checks++; if ({bu.count_sat, bu.done, bu.error} !== 3'b000)
            begin failures++; $display("FAIL reset_flags got=%b exp=000", {bu.count_sat, bu.done, bu.error}); end
        @(posedge clock); #1;
        reset_n = 1'b1;
    endtask

    task automatic test_unsigned();
        cyc_u(1, 0, 0, 8'd20);
        cyc_u(0, 0, 1, 8'd5);
        cyc_u(0, 0, 1, 8'd200);
        cyc_u(0, 0, 1, 8'd7);
        cyc_u(0, 1, 1, 8'd50);
        checks++; if (bu.done !== 1'b1)     begin failures++; $display("FAIL uns_done got=%b exp=1", bu.done); end
        checks++; if (bu.range !== 8'd195)  begin failures++; $display("FAIL uns_range got=%0d exp=195", bu.range); end
        checks++; if (bu.max_out !== 8'd200) begin failures++; $display("FAIL uns_max got=%0d exp=200", bu.max_out); end
        checks++; if (bu.min_out !== 8'd5)  begin failures++; $display("FAIL uns_min got=%0d exp=5", bu.min_out); end
        checks++; if (bu.count !== 8'd5)    begin failures++; $display("FAIL uns_count got=%0d exp=5", bu.count); end
        checks++; if (bu.count_sat !== 1'b0) begin failures++; $display("FAIL uns_sat got=%b exp=0", bu.count_sat); end
        cyc_u(0, 0, 0, 8'd0);
        checks++; if (bu.done !== 1'b0)     begin failures++; $display("FAIL uns_done_pulse got=%b exp=0", bu.done); end
        checks++; if (bu.range !== 8'd195)  begin failures++; $display("FAIL uns_hold got=%0d exp=195", bu.range); end
    endtask

    task automatic test_signed();
        cyc_s(1, 0, 0, 8'h9C);
        cyc_s(0, 0, 1, 8'd27);
        cyc_s(0, 1, 1, 8'd127);
        checks++; if (bs.done !== 1'b1)      begin failures++; $display("FAIL sgn_done got=%b exp=1", bs.done); end
        checks++; if (bs.range !== 8'd227)   begin failures++; $display("FAIL sgn_range got=%0d exp=227", bs.range); end
        checks++; if (bs.min_out !== 8'h9C)  begin failures++; $display("FAIL sgn_min got=%h exp=9c", bs.min_out); end
        checks++; if (bs.max_out !== 8'h7F)  begin failures++; $display("FAIL sgn_max got=%h exp=7f", bs.max_out); end
        checks++; if (bs.count !== 8'd3)     begin failures++; $display("FAIL sgn_count got=%0d exp=3", bs.count); end
        cyc_s(0, 0, 0, 8'd0);
    endtask

    task automatic test_go_in_run();
        cyc_u(1, 0, 0, 8'd30);
        cyc_u(1, 0, 0, 8'd99);
        checks++; if (bu.error !== 1'b1)    begin failures++; $display("FAIL gorun_error got=%b exp=1", bu.error); end
        checks++; if (bu.range !== 8'd195 || bu.count !== 8'd5)
            begin failures++; $display("FAIL gorun_hold got=%0d/%0d exp=195/5", bu.range, bu.count); end
        cyc_u(1, 0, 0, 8'd10);
        checks++; if (bu.error !== 1'b0)    begin failures++; $display("FAIL restart_error got=%b exp=0", bu.error); end
        cyc_u(0, 1, 1, 8'd10);
        checks++; if (bu.range !== 8'd0)    begin failures++; $display("FAIL restart_range got=%0d exp=0", bu.range); end
        checks++; if (bu.count !== 8'd2)    begin failures++; $display("FAIL restart_count got=%0d exp=2", bu.count); end
        checks++; if (bu.max_out !== 8'd10 || bu.min_out !== 8'd10)
            begin failures++; $display("FAIL restart_maxmin got=%0d/%0d exp=10/10", bu.max_out, bu.min_out); end
        cyc_u(0, 0, 0, 8'd0);
    endtask

    task automatic test_idle_finish();
        cyc_u(0, 1, 0, 8'd0);
        checks++; if (bu.error !== 1'b1)    begin failures++; $display("FAIL idlefin_error got=%b exp=1", bu.error); end
        checks++; if (bu.count !== 8'd2)    begin failures++; $display("FAIL idlefin_hold got=%0d exp=2", bu.count); end
        cyc_u(1, 0, 0, 8'd100);
        cyc_u(0, 0, 0, 8'd255);
        cyc_u(0, 0, 0, 8'd0);
        cyc_u(0, 1, 0, 8'd3);
        checks++; if (bu.max_out !== 8'd100 || bu.min_out !== 8'd100)
            begin failures++; $display("FAIL novalid_maxmin got=%0d/%0d exp=100/100", bu.max_out, bu.min_out); end
        checks++; if (bu.count !== 8'd1)    begin failures++; $display("FAIL novalid_count got=%0d exp=1", bu.count); end
        checks++; if (bu.error !== 1'b0)    begin failures++; $display("FAIL novalid_error got=%b exp=0", bu.error); end
        cyc_u(0, 0, 0, 8'd0);
    endtask

    task automatic test_saturation();
        cyc_c(1, 0, 0, 8'd1);
        for (int i = 1; i <= 5; i++) cyc_c(0, 0, 1, 8'(i));
        cyc_c(0, 1, 0, 8'd0);
        checks++; if (bc.count !== 2'd3)    begin failures++; $display("FAIL sat_count got=%0d exp=3", bc.count); end
        checks++; if (bc.count_sat !== 1'b1) begin failures++; $display("FAIL sat_flag got=%b exp=1", bc.count_sat); end
        checks++; if (bc.range !== 8'd4)    begin failures++; $display("FAIL sat_range got=%0d exp=4", bc.range); end
        cyc_c(0, 0, 0, 8'd0);
    endtask

    task automatic test_reset_midrun();
        cyc_u(1, 0, 0, 8'd40);
        cyc_u(0, 0, 1, 8'd60);
        #2;
        reset_n = 1'b0;
        #1;
        checks++; if (bu.max_out !== 8'd0 || bu.min_out !== 8'd0)
            begin failures++; $display("FAIL midrst_maxmin got=%0d/%0d exp=0/0", bu.max_out, bu.min_out); end
        checks++; if (bu.count !== 8'd0)    begin failures++; $display("FAIL midrst_count got=%0d exp=0", bu.count); end
        checks++; if (bc.count_sat !== 1'b0) begin failures++; $display("FAIL midrst_sat got=%b exp=0", bc.count_sat); end
        @(posedge clock); #1;
        reset_n = 1'b1;
        cyc_u(1, 0, 0, 8'd8);
        cyc_u(0, 0, 1, 8'd3);
        cyc_u(0, 1, 1, 8'd9);
        checks++; if (bu.done !== 1'b1)     begin failures++; $display("FAIL postrst_done got=%b exp=1", bu.done); end
        checks++; if (bu.max_out !== 8'd9 || bu.min_out !== 8'd3)
            begin failures++; $display("FAIL postrst_maxmin got=%0d/%0d exp=9/3", bu.max_out, bu.min_out); end
        checks++; if (bu.count !== 8'd3 || bu.range !== 8'd6)
            begin failures++; $display("FAIL postrst_count_range got=%0d/%0d exp=3/6", bu.count, bu.range); end
    endtask

    initial begin
        bu.go = 1'b0; bu.finish = 1'b0; bu.data_valid = 1'b0; bu.data_in = '0;
        bs.go = 1'b0; bs.finish = 1'b0; bs.data_valid = 1'b0; bs.data_in = '0;
        bc.go = 1'b0; bc.finish = 1'b0; bc.data_valid = 1'b0; bc.data_in = '0;
        test_reset();
        test_unsigned();
        test_signed();
        test_go_in_run();
        test_idle_finish();
        test_saturation();
        test_reset_midrun();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout reached");
        $fatal(1);
    end

endmodule
